// File: rtl/dpu_trace_buffer.sv
// dpu_trace_buffer: timestamped multi-probe event tracer with pre/post-trigger capture and a valid/ready drain port
module dpu_trace_buffer #(
  parameter int N_PROBES = 4,
  parameter int DATA_W = 32,
  parameter int TS_W = 24,
  parameter int DEPTH = 256,
  parameter int ID_W = $clog2(N_PROBES),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PROBES-1:0]        probe_valid,
  input  logic [N_PROBES*DATA_W-1:0] probe_data,
  input  logic [N_PROBES-1:0]        probe_en,
  input  logic                       mode_wrap,
  input  logic                       arm,
  input  logic                       stop,
  input  logic                       trig_en,
  input  logic [ID_W-1:0]            trig_id,
  input  logic [DATA_W-1:0]          trig_data,
  input  logic [DATA_W-1:0]          trig_mask,
  input  logic [CNT_W-1:0]           post_count,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ID_W-1:0]            rd_id,
  output logic [TS_W-1:0]            rd_ts,
  output logic [DATA_W-1:0]          rd_data,
  output logic [1:0]                 state,
  output logic [CNT_W-1:0]           count,
  output logic                       triggered,
  output logic [15:0]                drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = ID_W + TS_W + DATA_W;
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TS_W-1:0] ts;
  logic [CNT_W-1:0] remaining;
  logic wrap, limited, done_d;
  logic [ID_W-1:0] tid;
  logic [DATA_W-1:0] tdata, tmask;
  logic [N_PROBES-1:0] act;
  logic [ID_W-1:0] win;
  logic [ID_W:0] n_act;
  logic [16:0] drop_sum;
  logic any, hit, run, full, store, cstore, fin, done_lim, pop, fetch;
  logic [1:0] nxt;
  always_comb begin
    act = probe_valid & probe_en;
    win = '0;
    any = 1'b0;
    n_act = '0;
    for (int i = N_PROBES - 1; i >= 0; i--) if (act[i]) begin
      win = ID_W'(i);
      any = 1'b1;
    end
    for (int i = 0; i < N_PROBES; i++) n_act = n_act + (ID_W+1)'(act[i]);
    run = state == ARMED || state == CAPTURE;
    hit = !arm && state == ARMED && act[tid] &&
          ((probe_data[tid*DATA_W +: DATA_W] ^ tdata) & tmask) == '0;
    win = hit ? tid : win;
    full = count == CNT_W'(DEPTH);
    // ARMED is a pure ring; CAPTURE honours stop-when-full
    store = any && !arm && (state == ARMED || (state == CAPTURE && (wrap || !full)));
    cstore = hit || (state == CAPTURE && store);
    done_lim = cstore && limited && remaining == CNT_W'(1);
    fin = state == CAPTURE && !wrap && (full || (store && count == CNT_W'(DEPTH - 1)));
    nxt = arm ? (trig_en ? ARMED : CAPTURE) :
          (run && (stop || fin || done_lim)) ? DONE :
          hit ? CAPTURE : state;
    drop_sum = {1'b0, drop_cnt} + 17'(n_act) - 17'd1;
    pop = state == DONE && rd_valid && rd_ready;
    fetch = state == DONE && done_d && !rd_valid && count != '0;
  end
  always_ff @(posedge clk) if (store) mem[wr_ptr] <= {win, ts, probe_data[win*DATA_W +: DATA_W]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      done_d <= 1'b0;
      ts <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      triggered <= 1'b0;
      drop_cnt <= '0;
      rd_valid <= 1'b0;
      rd_id <= '0;
      rd_ts <= '0;
      rd_data <= '0;
      wrap <= 1'b0;
      limited <= 1'b0;
      remaining <= '0;
      tid <= '0;
      tdata <= '0;
      tmask <= '0;
    end else begin
      state <= nxt;
      done_d <= state == DONE;
      ts <= arm ? '0 : ts + 1'b1;
      if (arm) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        triggered <= 1'b0;
        drop_cnt <= '0;
        rd_valid <= 1'b0;
        wrap <= mode_wrap;
        tid <= trig_id;
        tdata <= trig_data;
        tmask <= trig_mask;
        remaining <= post_count;
        limited <= post_count != '0;
      end else begin
        if (store) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (full) rd_ptr <= rd_ptr + 1'b1;
          else count <= count + 1'b1;
          drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
        if (hit) triggered <= 1'b1;
        if (cstore && limited) remaining <= remaining - 1'b1;
        // a pop leaves one bubble cycle while the next entry is read out
        if (pop) begin
          rd_valid <= 1'b0;
          rd_ptr <= rd_ptr + 1'b1;
          count <= count - 1'b1;
        end
        if (fetch) begin
          rd_valid <= 1'b1;
          {rd_id, rd_ts, rd_data} <= mem[rd_ptr];
        end
      end
    end
endmodule

// File: tb/tb_dpu_trace_buffer.sv
// tb_dpu_trace_buffer: table-driven capture scenarios plus hand-written trigger/reset/re-arm sequences, scoreboarded drain
module tb_dpu_trace_buffer;
  localparam int N = 4, DW = 16, TW = 16, D = 8, IW = 2, CW = 4;
  logic clk = 0, rst = 1;
  logic [N-1:0] probe_valid = '0, probe_en = '1;
  logic [N*DW-1:0] probe_data = '0;
  logic mode_wrap = 0, arm = 0, stop = 0, trig_en = 0, rd_ready = 0;
  logic [IW-1:0] trig_id = '0;
  logic [DW-1:0] trig_data = '0, trig_mask = '0;
  logic [CW-1:0] post_count = '0;
  logic rd_valid, triggered;
  logic [IW-1:0] rd_id;
  logic [TW-1:0] rd_ts;
  logic [DW-1:0] rd_data;
  logic [1:0] state;
  logic [CW-1:0] count;
  logic [15:0] drop_cnt;
  int errors = 0, checks = 0;

  typedef struct {logic [1:0] id; int ts; logic [15:0] data;} ent_t;
  typedef struct {logic wrap; logic [3:0] en; logic [3:0] valid; int cycles; logic do_stop;
                  int exp_cnt; int exp_drop; int exp_ts0; logic [1:0] exp_id;} vec_t;
  ent_t sb[$];
  vec_t vecs[4];

  dpu_trace_buffer #(.N_PROBES(N), .DATA_W(DW), .TS_W(TW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .probe_valid(probe_valid), .probe_data(probe_data), .probe_en(probe_en),
    .mode_wrap(mode_wrap), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_id(trig_id),
    .trig_data(trig_data), .trig_mask(trig_mask), .post_count(post_count), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_id(rd_id), .rd_ts(rd_ts), .rd_data(rd_data), .state(state),
    .count(count), .triggered(triggered), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  function automatic logic [15:0] pdata(int i, int c);
    return 16'((i << 12) | c);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_probes(input logic [3:0] v, input int c);
    probe_valid = v;
    for (int i = 0; i < N; i++) probe_data[i*DW +: DW] = pdata(i, c);
  endtask

  task automatic start(input logic w, input logic te, input int id, input int td, input int pc);
    mode_wrap = w; trig_en = te; trig_id = IW'(id); trig_data = DW'(td);
    trig_mask = 16'h00FF; post_count = CW'(pc);
    arm = 1;
    tick();
    arm = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (state != 2'd3 && n < 100) begin tick(); n++; end
    chk("reach DONE", int'(state), 3);
  endtask

  task automatic drain();
    int n = 0;
    ent_t e;
    rd_ready = 1;
    while (sb.size() > 0 && n < 200) begin
      if (rd_valid) begin
        e = sb.pop_front();
        chk("rd_id", int'(rd_id), int'(e.id));
        chk("rd_ts", int'(rd_ts), e.ts);
        chk("rd_data", int'(rd_data), int'(e.data));
      end
      tick();
      n++;
    end
    chk("drain leftover", sb.size(), 0);
    sb.delete();
    tick();
    chk("drained count", int'(count), 0);
    chk("drained rd_valid", int'(rd_valid), 0);
    rd_ready = 0;
  endtask

  initial begin
    vecs[0] = '{wrap: 0, en: 4'hF, valid: 4'b0001, cycles: 20, do_stop: 1, exp_cnt: 8, exp_drop: 0, exp_ts0: 0,  exp_id: 0};
    vecs[1] = '{wrap: 1, en: 4'hF, valid: 4'b0010, cycles: 20, do_stop: 1, exp_cnt: 8, exp_drop: 0, exp_ts0: 12, exp_id: 1};
    vecs[2] = '{wrap: 0, en: 4'hF, valid: 4'b1011, cycles: 4,  do_stop: 1, exp_cnt: 4, exp_drop: 8, exp_ts0: 0,  exp_id: 0};
    vecs[3] = '{wrap: 0, en: 4'hE, valid: 4'b0001, cycles: 5,  do_stop: 1, exp_cnt: 0, exp_drop: 0, exp_ts0: 0,  exp_id: 0};
    #2;
    chk("reset state", int'(state), 0);
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset count", int'(count), 0);
    chk("reset drop", int'(drop_cnt), 0);
    chk("reset rd_ts", int'(rd_ts), 0);
    tick();
    rst = 0;
    tick();

    foreach (vecs[k]) begin
      probe_en = vecs[k].en;
      start(vecs[k].wrap, 0, 0, 0, 0);
      for (int c = 0; c < vecs[k].cycles; c++) begin set_probes(vecs[k].valid, c); tick(); end
      probe_valid = '0;
      if (vecs[k].do_stop) begin stop = 1; tick(); stop = 0; end
      wait_done();
      chk($sformatf("v%0d count", k), int'(count), vecs[k].exp_cnt);
      chk($sformatf("v%0d drop", k), int'(drop_cnt), vecs[k].exp_drop);
      chk($sformatf("v%0d triggered", k), int'(triggered), 0);
      for (int j = 0; j < vecs[k].exp_cnt; j++)
        sb.push_back('{id: vecs[k].exp_id, ts: vecs[k].exp_ts0 + j, data: pdata(vecs[k].exp_id, vecs[k].exp_ts0 + j)});
      drain();
    end
    probe_en = '1;

    // pre/post trigger around probe2 == 0xAB
    start(1, 1, 2, 8'hAB, 3);
    chk("armed state", int'(state), 1);
    for (int c = 0; c < 15; c++) begin
      set_probes(c == 10 ? 4'b0101 : 4'b0001, c);
      if (c == 10) probe_data[2*DW +: DW] = 16'h00AB;
      tick();
      if (c == 10) begin
        chk("trig triggered", int'(triggered), 1);
        chk("trig state", int'(state), 2);
      end
      if (c == 12) begin
        chk("trig done", int'(state), 3);
        chk("trig rd_valid lat0", int'(rd_valid), 0);
      end
      if (c == 13) chk("trig rd_valid lat1", int'(rd_valid), 0);
      if (c == 14) chk("trig rd_valid lat2", int'(rd_valid), 1);
    end
    probe_valid = '0;
    chk("trig drop", int'(drop_cnt), 1);
    chk("trig count", int'(count), 8);
    for (int t = 5; t <= 12; t++)
      sb.push_back(t == 10 ? '{id: 2'd2, ts: 10, data: 16'h00AB} : '{id: 2'd0, ts: t, data: pdata(0, t)});
    tick(); tick();
    chk("hold rd_valid", int'(rd_valid), 1);
    chk("hold rd_ts", int'(rd_ts), 5);
    rd_ready = 1;
    tick();
    void'(sb.pop_front());
    chk("bubble rd_valid", int'(rd_valid), 0);
    tick();
    chk("next rd_valid", int'(rd_valid), 1);
    chk("next rd_ts", int'(rd_ts), 6);
    drain();

    // async reset mid-capture; rd_ts is nonzero from the last pop
    start(0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin set_probes(4'b0001, c); tick(); end
    rst = 1;
    #1;
    chk("rst state", int'(state), 0);
    chk("rst count", int'(count), 0);
    chk("rst rd_ts", int'(rd_ts), 0);
    chk("rst rd_id", int'(rd_id), 0);
    probe_valid = '0;
    #3 rst = 0;
    tick();

    // re-arm during capture discards buffer and restarts timestamps
    start(0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin set_probes(4'b0011, c); tick(); end
    chk("rearm pre count", int'(count), 3);
    chk("rearm pre drop", int'(drop_cnt), 3);
    arm = 1;
    tick();
    arm = 0;
    chk("rearm count", int'(count), 0);
    chk("rearm drop", int'(drop_cnt), 0);
    set_probes(4'b0001, 0);
    tick();
    probe_valid = '0;
    stop = 1; tick(); stop = 0;
    wait_done();
    sb.push_back('{id: 2'd0, ts: 0, data: pdata(0, 0)});
    drain();

    // stop with nothing captured
    start(0, 1, 3, 0, 0);
    tick(); tick();
    stop = 1; tick(); stop = 0;
    chk("empty state", int'(state), 3);
    tick(); tick(); tick();
    chk("empty rd_valid", int'(rd_valid), 0);
    chk("empty count", int'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dpu_trace_buffer.md
# dpu_trace_buffer

Parametrised on-chip event tracer for the DPU: captures timestamped events from N probe channels into a circular buffer. Probe sources include engine output pulses, FSM state changes and MAC/post-process valids. Supports pre/post-trigger capture around a programmable trigger, with wrap and stop-when-full modes. Sits beside `dpu_top`; the host drains it through a valid/ready pop port, which replaces simulation-only `$display` monitors with silicon-visible trace.

## Interface
Parameters:
- `N_PROBES`, 4: probe channels (≥2).
- `DATA_W`, 32: payload width per probe.
- `TS_W`, 24: timestamp width.
- `DEPTH`, 256: buffer entries; power of two.
- `ID_W`, `$clog2(N_PROBES)`: derived; probe-id width.
- `CNT_W`, `$clog2(DEPTH)+1`: derived; occupancy/post-count width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `probe_valid` in N_PROBES: per-probe event strobe.
- `probe_data` in N_PROBES*DATA_W: payload; probe i occupies bits [i*DATA_W +: DATA_W].
- `probe_en` in N_PROBES: per-probe capture enable; a disabled probe is fully ignored.
- `mode_wrap` in 1: 0 = stop when full, 1 = overwrite oldest.
- `arm` in 1: pulse; clear buffer and start a run.
- `stop` in 1: pulse; force DONE.
- `trig_en` in 1: 0 = capture immediately on arm.
- `trig_id` in ID_W: trigger probe.
- `trig_data`, `trig_mask` in DATA_W: trigger compare value and mask (1 = compare bit).
- `post_count` in CNT_W: entries to store from trigger onward, trigger entry included; 0 = unlimited.
- `rd_valid` out 1; `rd_ready` in 1: pop handshake.
- `rd_id` out ID_W; `rd_ts` out TS_W; `rd_data` out DATA_W: oldest entry.
- `state` out 2: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- `count` out CNT_W: occupancy.
- `triggered` out 1.
- `drop_cnt` out 16: events lost to arbitration; saturates at 0xFFFF.

## Operation
- Sample `mode_wrap`, `trig_*` and `post_count` only in the cycle `arm` is high; they are ignored afterwards.
- Timestamp counter:
  - Set to 0 on the arm cycle, +1 every later cycle.
  - Wraps silently at TS_W.
  - An event's ts is the counter value in the cycle it is stored.
- Arbitration: at most one entry stored per cycle.
  - The candidate is the lowest-index enabled valid probe.
  - If a trigger fires this cycle, the trigger probe wins instead.
  - Every other enabled valid probe increments `drop_cnt`.
- Trigger match: `probe_valid[trig_id] & probe_en[trig_id] & ((probe_data[trig_id]^trig_data)&trig_mask)==0`.
- IDLE:
  - No capture.
  - On `arm`: clear pointers, `count`, `triggered` and `drop_cnt`; go to ARMED if `trig_en`, else CAPTURE.
- ARMED:
  - Store events as a ring; always overwrite when full, regardless of `mode_wrap`.
  - On trigger match: store the trigger event, set `triggered`, load remaining = `post_count`−1, go to CAPTURE.
  - If `post_count`==1, go directly to DONE.
- CAPTURE:
  - Store events.
  - When full: with `mode_wrap`=0 the store that makes `count`==DEPTH is the last, then go to DONE; with `mode_wrap`=1 overwrite the oldest.
  - Remaining decrements per store when `post_count`≠0; the store that reaches 0 goes to DONE.
- DONE:
  - No capture; the pop port is active.
  - A pop decrements `count`.
  - `rd_valid` is 0 when `count`==0.
- `rd_valid` is 0 in every state other than DONE.
- `stop` in ARMED or CAPTURE → DONE next cycle; a store in the same cycle still completes. `stop` in IDLE or DONE is ignored.
- `arm` in any state restarts the run and discards the buffer.
- `arm` and `stop` together: `arm` wins.
- In the arm cycle itself, probes are ignored.

## Timing
- Reset: `state`=IDLE, `rd_valid`=0, and `rd_id`/`rd_ts`/`rd_data`/`count`/`triggered`/`drop_cnt` are all 0. The timestamp counter resets to 0.
- Store: probe sampled in cycle t → `count` updated at t+1.
- Read port:
  - Outputs are registered from the memory.
  - On entry to DONE with `count`>0, `rd_valid` rises 2 cycles later.
  - After each pop (`rd_valid & rd_ready`), `rd_valid` is low for 1 cycle, then the next entry is presented.
  - Throughput is 1 entry per 2 cycles.
- `rd_*` remain stable while `rd_valid & !rd_ready`.
- `state`, `triggered` and `drop_cnt` are registered and visible 1 cycle after the causing event.

## Test plan
- **Immediate capture, stop-when-full:** `trig_en`=0, `mode_wrap`=0, DEPTH=8, probe0 valid every cycle for 20 cycles after arm → DONE with `count`=8; pops return ts 0..7 and id 0; `drop_cnt`=0.
- **Wrap mode with stop:** `mode_wrap`=1, DEPTH=8, probe1 valid for 20 cycles, then `stop` → `count`=8; pops return ts 12..19.
- **Pre/post trigger:** DEPTH=8, `trig_id`=2, `trig_data`=0xAB, `trig_mask`=0xFF, `post_count`=3.
  - Stimulus: probe0 events at ts 0..9, then probe2=0xAB at ts 10 with probe0 also valid, then probe0 at ts 11..14.
  - Response: entry (id 2, ts 10) is stored, `drop_cnt`=1, DONE after the ts 12 store; pops return ts 5..9, 10(id 2), 11, 12.
- **Arbitration:** probes 0, 1 and 3 valid together for 4 cycles → 4 entries, all id 0; `drop_cnt`=8.
- **Masking and reset:**
  - `probe_en`=4'b1110 with only probe0 active → `count` stays 0.
  - Assert `rst` mid-CAPTURE → all outputs return to their reset values immediately.
- **Re-arm and empty read:**
  - `arm` during CAPTURE → `count` and `drop_cnt` are 0 next cycle, and the next stored ts is 0.
  - `stop` with an empty buffer → DONE with `rd_valid`=0.
